cmplx_mult_pipe: RTL and testbench

- Parametrised, pipelined complex multiplier: computes y = a·b (or a·conj(b) when the optional feature is compiled in).
- Selectable rounding, symmetric-range saturation, valid/ready backpressure and a saturation-event counter.
- Sits in the baseband datapath between the mixer/NCO and the channel filters. Supersedes the fixed 18-bit single-cycle multiplier.

---
 rtl/cmplx_mult_pkg.sv | 15 +
 rtl/cmplx_round_sat.sv | 54 +++++
 rtl/cmplx_mult_pipe.sv | 160 ++++++++++++++++
 tb/tb_cmplx_mult_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmplx_mult_pkg.sv
// Shared types and helpers for the pipelined complex multiplier.
package cmplx_mult_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC   = 2'd0,
        RND_HALF_UP = 2'd1,
        RND_CONV    = 2'd2
    } rnd_mode_e;

    // Width of a cross-term sum: two full IN_W x IN_W products plus one guard bit.
    function automatic int prod_w(input int in_w);
        return 2 * in_w + 1;
    endfunction

endpackage

// File: rtl/cmplx_round_sat.sv
// Combinational round, shift right by FRAC_B and symmetric saturation for one
// component of the complex product.
module cmplx_round_sat
    import cmplx_mult_pkg::*;
#(
    parameter int IN_WIDTH = 37,
    parameter int FRAC_B   = 16,
    parameter int OUT_W    = 18,
    parameter int RND_MODE = 1
) (
    input  logic [IN_WIDTH-1:0] din,
    output logic [OUT_W-1:0]    value,
    output logic                sat
);

    // One extra bit so adding the rounding bias can never wrap.
    localparam int EW = IN_WIDTH + 1;
    localparam logic signed [EW-1:0] ONE_V  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] HALF_V = ONE_V <<< (FRAC_B - 1);
    localparam logic signed [EW-1:0] MAX_V  = (ONE_V <<< (OUT_W - 1)) - ONE_V;
    localparam logic signed [EW-1:0] MIN_V  = -MAX_V;

    logic signed [EW-1:0] ext_s;
    logic signed [EW-1:0] bias_s;
    logic signed [EW-1:0] sum_s;
    logic signed [EW-1:0] rnd_s;

    assign ext_s = {din[IN_WIDTH-1], din};

    // Bias selection, then floor-shift and clamp to the symmetric range.
    always_comb begin
        bias_s = '0;
        case (rnd_mode_e'(RND_MODE))
            RND_TRUNC:   bias_s = '0;
            RND_HALF_UP: bias_s = HALF_V;
            // half-1 plus the LSB of the kept part: ties carry only when that LSB is odd
            RND_CONV:    bias_s = HALF_V - ONE_V + {{(EW-1){1'b0}}, din[FRAC_B]};
            default:     bias_s = '0;
        endcase
        sum_s = ext_s + bias_s;
        rnd_s = sum_s >>> FRAC_B;
        if (rnd_s > MAX_V) begin
            value = MAX_V[OUT_W-1:0];
            sat   = 1'b1;
        end else if (rnd_s < MIN_V) begin
            value = MIN_V[OUT_W-1:0];
            sat   = 1'b1;
        end else begin
            value = rnd_s[OUT_W-1:0];
            sat   = 1'b0;
        end
    end

endmodule

// File: rtl/cmplx_mult_pipe.sv
// Four-stage pipelined complex multiplier with valid/ready backpressure,
// rounding, symmetric saturation and a saturation counter.
// Define CMPLX_MULT_CONJ_EN to add conj_i and compute a*conj(b).
module cmplx_mult_pipe
    import cmplx_mult_pkg::*;
#(
    parameter int IN_W      = 18,
    parameter int FRAC_B    = 16,
    parameter int OUT_W     = 18,
    parameter int RND_MODE  = 1,
    parameter int SAT_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IN_W-1:0]      a_i_i,
    input  logic [IN_W-1:0]      a_q_i,
    input  logic [IN_W-1:0]      b_i_i,
    input  logic [IN_W-1:0]      b_q_i,
`ifdef CMPLX_MULT_CONJ_EN
    input  logic                 conj_i,
`endif
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OUT_W-1:0]     data_i_o,
    output logic [OUT_W-1:0]     data_q_o,
    output logic                 sat_o,
    input  logic                 sat_clr_i,
    output logic [SAT_CNT_W-1:0] sat_cnt_o
);

    localparam int PW = prod_w(IN_W);
`ifdef CMPLX_MULT_CONJ_EN
    localparam int BQ_W = IN_W + 1;
`else
    localparam int BQ_W = IN_W;
`endif

    logic                   advance_s;
    logic                   v1_r, v2_r, v3_r;
    logic signed [IN_W-1:0] a_i_r, a_q_r, b_i_r;
    logic signed [BQ_W-1:0] b_q_s, b_q_r;
    logic signed [PW-1:0]   p_ii_r, p_qq_r, p_iq_r, p_qi_r;
    logic signed [PW-1:0]   pr_r, pq_r;
    logic [OUT_W-1:0]       rs_i_s, rs_q_s;
    logic                   sat_i_s, sat_q_s;

    assign advance_s  = !out_valid_o || out_ready_i;
    assign in_ready_o = advance_s;

    // Optional conjugation; the extra bit keeps -(-2^(IN_W-1)) exact.
    always_comb begin
`ifdef CMPLX_MULT_CONJ_EN
        if (conj_i) begin
            b_q_s = -{b_q_i[IN_W-1], b_q_i};
        end else begin
            b_q_s = {b_q_i[IN_W-1], b_q_i};
        end
`else
        b_q_s = b_q_i;
`endif
    end

    // S1: operand registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            v1_r  <= 1'b0;
            a_i_r <= '0;
            a_q_r <= '0;
            b_i_r <= '0;
            b_q_r <= '0;
        end else if (advance_s) begin
            v1_r  <= in_valid_i;
            a_i_r <= a_i_i;
            a_q_r <= a_q_i;
            b_i_r <= b_i_i;
            b_q_r <= b_q_s;
        end
    end

    // S2: the four partial products, sign-extended to the sum width.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            v2_r   <= 1'b0;
            p_ii_r <= '0;
            p_qq_r <= '0;
            p_iq_r <= '0;
            p_qi_r <= '0;
        end else if (advance_s) begin
            v2_r   <= v1_r;
            p_ii_r <= PW'(a_i_r) * PW'(b_i_r);
            p_qq_r <= PW'(a_q_r) * PW'(b_q_r);
            p_iq_r <= PW'(a_i_r) * PW'(b_q_r);
            p_qi_r <= PW'(a_q_r) * PW'(b_i_r);
        end
    end

    // S3: real and imaginary sums at full precision.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            v3_r <= 1'b0;
            pr_r <= '0;
            pq_r <= '0;
        end else if (advance_s) begin
            v3_r <= v2_r;
            pr_r <= p_ii_r - p_qq_r;
            pq_r <= p_iq_r + p_qi_r;
        end
    end

    cmplx_round_sat #(
        .IN_WIDTH (PW),
        .FRAC_B   (FRAC_B),
        .OUT_W    (OUT_W),
        .RND_MODE (RND_MODE)
    ) u_rs_i (
        .din   (pr_r),
        .value (rs_i_s),
        .sat   (sat_i_s)
    );

    cmplx_round_sat #(
        .IN_WIDTH (PW),
        .FRAC_B   (FRAC_B),
        .OUT_W    (OUT_W),
        .RND_MODE (RND_MODE)
    ) u_rs_q (
        .din   (pq_r),
        .value (rs_q_s),
        .sat   (sat_q_s)
    );

    // S4: registered outputs.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            out_valid_o <= 1'b0;
            data_i_o    <= '0;
            data_q_o    <= '0;
            sat_o       <= 1'b0;
        end else if (advance_s) begin
            out_valid_o <= v3_r;
            data_i_o    <= rs_i_s;
            data_q_o    <= rs_q_s;
            sat_o       <= sat_i_s | sat_q_s;
        end
    end

    // Saturation-event counter: clear wins, sticks at all-ones.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sat_cnt_o <= '0;
        end else if (sat_clr_i) begin
            sat_cnt_o <= '0;
        end else if (out_valid_o && out_ready_i && sat_o && (sat_cnt_o != {SAT_CNT_W{1'b1}})) begin
            sat_cnt_o <= sat_cnt_o + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// Scoreboard bench: three DUTs (truncate / half-up / convergent) share one
// stimulus stream; expected results are queued on acceptance and popped by a monitor.
module tb_cmplx_mult_pipe;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sat_clr = 1'b0;
    logic [17:0] a_i = '0, a_q = '0, b_i = '0, b_q = '0;
`ifdef CMPLX_MULT_CONJ_EN
    logic        conj = 1'b0;
`endif
    logic [2:0]  ir, ov, st;
    logic [17:0] di [3];
    logic [17:0] dq [3];
    logic [1:0]  cnt0, cnt2;
    logic [15:0] cnt1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int popped = 0;

    typedef struct {
        int e0_i, e1_i, e2_i;
        int e0_q, e1_q, e2_q;
        bit sat;
        int acc;
        bit lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmplx_mult_pipe #(.RND_MODE(0), .SAT_CNT_W(2)) dut_t (
        .clk_i(clk), .arstn_i(arstn), .in_valid_i(in_valid), .in_ready_o(ir[0]),
        .a_i_i(a_i), .a_q_i(a_q), .b_i_i(b_i), .b_q_i(b_q),
`ifdef CMPLX_MULT_CONJ_EN
        .conj_i(conj),
`endif
        .out_valid_o(ov[0]), .out_ready_i(out_ready), .data_i_o(di[0]), .data_q_o(dq[0]),
        .sat_o(st[0]), .sat_clr_i(sat_clr), .sat_cnt_o(cnt0));

    cmplx_mult_pipe #(.RND_MODE(1), .SAT_CNT_W(16)) dut (
        .clk_i(clk), .arstn_i(arstn), .in_valid_i(in_valid), .in_ready_o(ir[1]),
        .a_i_i(a_i), .a_q_i(a_q), .b_i_i(b_i), .b_q_i(b_q),
`ifdef CMPLX_MULT_CONJ_EN
        .conj_i(conj),
`endif
        .out_valid_o(ov[1]), .out_ready_i(out_ready), .data_i_o(di[1]), .data_q_o(dq[1]),
        .sat_o(st[1]), .sat_clr_i(sat_clr), .sat_cnt_o(cnt1));

    cmplx_mult_pipe #(.RND_MODE(2), .SAT_CNT_W(2)) dut_c (
        .clk_i(clk), .arstn_i(arstn), .in_valid_i(in_valid), .in_ready_o(ir[2]),
        .a_i_i(a_i), .a_q_i(a_q), .b_i_i(b_i), .b_q_i(b_q),
`ifdef CMPLX_MULT_CONJ_EN
        .conj_i(conj),
`endif
        .out_valid_o(ov[2]), .out_ready_i(out_ready), .data_i_o(di[2]), .data_q_o(dq[2]),
        .sat_o(st[2]), .sat_clr_i(sat_clr), .sat_cnt_o(cnt2));

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Drive one sample at the falling edge and hold it until accepted.
    task automatic send(input int ai, input int aq, input int bi, input int bq,
                        input int e0i, input int e1i, input int e2i,
                        input int e0q, input int e1q, input int e2q,
                        input bit s, input bit lat);
        exp_t e;
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        a_i = ai[17:0];
        a_q = aq[17:0];
        b_i = bi[17:0];
        b_q = bq[17:0];
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            #1;
            if (ir[1]) begin
                e.e0_i = e0i; e.e1_i = e1i; e.e2_i = e2i;
                e.e0_q = e0q; e.e1_q = e1q; e.e2_q = e2q;
                e.sat = s; e.acc = cyc; e.lat = lat;
                sbq.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            if (!ok) @(negedge clk);
        end
        chk("accept", int'(ok), 1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sbq.size() != 0; t++) @(negedge clk);
        chk("drain_left", sbq.size(), 0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Monitor: pops and compares on every output transfer.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            #1;
            if (arstn && ov[1] && out_ready) begin
                chk("valid_agree", int'(ov), 7);
                if (sbq.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    m = sbq.pop_front();
                    popped++;
                    chk("i_trunc", $signed(di[0]), m.e0_i);
                    chk("i_half",  $signed(di[1]), m.e1_i);
                    chk("i_conv",  $signed(di[2]), m.e2_i);
                    chk("q_trunc", $signed(dq[0]), m.e0_q);
                    chk("q_half",  $signed(dq[1]), m.e1_q);
                    chk("q_conv",  $signed(dq[2]), m.e2_q);
                    chk("sat", int'(st), m.sat ? 7 : 0);
                    if (m.lat) chk("latency", cyc - m.acc, 4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int held_i, held_q, p0, stale;
        bit seen;
        #3;
        chk("rst_valid", int'(ov), 0);
        chk("rst_data_i", int'(di[1]), 0);
        chk("rst_cnt", int'(cnt1), 0);
        @(negedge clk);
        arstn = 1'b1;
        repeat (2) @(negedge clk);

        send(1000, -700, 65536, 0, 1000, 1000, 1000, -700, -700, -700, 1'b0, 1'b1);
        send(5, 0, 32768, 0, 2, 3, 2, 0, 0, 0, 1'b0, 1'b0);
        send(-5, 0, 32768, 0, -3, -2, -2, 0, 0, 0, 1'b0, 1'b0);
        send(7, 0, 32768, 0, 3, 4, 4, 0, 0, 0, 1'b0, 1'b0);
        send(0, 5, 32768, 0, 0, 0, 0, 2, 3, 2, 1'b0, 1'b0);
        send(300, 200, 65536, 65536, 100, 100, 100, 500, 500, 500, 1'b0, 1'b0);
        send(131071, 131071, 131071, -131071, 131071, 131071, 131071, 0, 0, 0, 1'b1, 1'b0);
        send(-131072, 0, -131072, 0, 131071, 131071, 131071, 0, 0, 0, 1'b1, 1'b0);
        send(-131072, 0, 65536, 0, -131071, -131071, -131071, 0, 0, 0, 1'b1, 1'b0);
`ifdef CMPLX_MULT_CONJ_EN
        idle();
        conj = 1'b1;
        send(65536, 0, 0, 65536, 0, 0, 0, -65536, -65536, -65536, 1'b0, 1'b0);
        idle();
        conj = 1'b0;
`endif
        idle();
        drain();
        chk("cnt16_after3", int'(cnt1), 3);
        chk("cnt2_after3", int'(cnt0), 3);

        repeat (2) send(131071, 131071, 131071, -131071, 131071, 131071, 131071, 0, 0, 0, 1'b1, 1'b0);
        idle();
        drain();
        chk("cnt16_after5", int'(cnt1), 5);
        chk("cnt2_hold_t", int'(cnt0), 3);
        chk("cnt2_hold_c", int'(cnt2), 3);

        // Clear coinciding with a saturating output transfer.
        send(131071, 131071, 131071, -131071, 131071, 131071, 131071, 0, 0, 0, 1'b1, 1'b0);
        idle();
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            #1;
            if (ov[1] && st[1]) seen = 1'b1;
        end
        chk("clr_wait", int'(seen), 1);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        #1;
        chk("clr_cnt16", int'(cnt1), 0);
        chk("clr_cnt2", int'(cnt0), 0);
        drain();

        // Backpressure: out_ready low for stream cycles 6..8.
        p0 = popped;
        fork
            begin
                for (int k = 0; k < 10; k++)
                    send(100 * k + 1, -(k + 1), 65536, 0, 100 * k + 1, 100 * k + 1, 100 * k + 1,
                         -(k + 1), -(k + 1), -(k + 1), 1'b0, 1'b0);
                idle();
            end
            begin
                for (int sc = 0; sc < 12; sc++) begin
                    @(negedge clk);
                    out_ready = !(sc >= 6 && sc <= 8);
                    #1;
                    if (sc >= 6 && sc <= 8) begin
                        chk("stall_in_ready", int'(ir[1]), 0);
                        chk("stall_valid", int'(ov[1]), 1);
                        if (sc == 6) begin
                            held_i = $signed(di[1]);
                            held_q = $signed(dq[1]);
                        end else begin
                            chk("stall_hold_i", $signed(di[1]), held_i);
                            chk("stall_hold_q", $signed(dq[1]), held_q);
                        end
                    end
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", popped - p0, 10);

        // Reset with samples still in flight.
        repeat (5) send(131071, 131071, 131071, -131071, 131071, 131071, 131071, 0, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("pre_rst_valid", int'(ov[1]), 1);
        chk("pre_rst_cnt", int'(cnt1), 1);
        arstn = 1'b0;
        #1;
        chk("arst_valid", int'(ov), 0);
        chk("arst_data_i", int'(di[1]), 0);
        chk("arst_data_q", int'(dq[1]), 0);
        chk("arst_sat", int'(st), 0);
        chk("arst_cnt", int'(cnt1), 0);
        sbq.delete();
        @(negedge clk);
        arstn = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (ov != 3'b000) stale++;
        end
        chk("stale_valid", stale, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
